// File: rtl/pack_poly_sequencer.sv
// pack_poly_sequencer: walks one polynomial through the group packer,
// one 8-coefficient group at a time, from coefficient RAM to ciphertext buffer.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start/busy/done      launch handshake toward the ciphertext-packing FSM
//   error                watchdog abort flag, held until the next accepted start
//   coef_rd_*            coefficient RAM read port (1-cycle read latency)
//   pk_enable/pk_coeffs  packer launch pulse and the registered group
//   pk_done/pk_group     packer completion pulse and packed result
//   ct_wr_*              ciphertext buffer write port
//
// Build option: define PACK_SEQ_WDOG_EN to build the WAIT-state watchdog.
// Without it WAIT blocks until pk_done and error is tied low.
module pack_poly_sequencer #(
   parameter int KYBER_N          = 256,
   parameter int GROUP_COEFFS     = 8,
   parameter int COEFF_WIDTH      = 12,
   parameter int GROUP_OUT_WIDTH  = 24,
   parameter int GROUP_ADDR_WIDTH = 5,
   parameter int WDOG_LIMIT       = 255
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic                                error,
   output logic                                coef_rd_en,
   output logic [GROUP_ADDR_WIDTH-1:0]         coef_rd_addr,
   input  logic [COEFF_WIDTH*GROUP_COEFFS-1:0] coef_rd_data,
   output logic                                pk_enable,
   output logic [COEFF_WIDTH*GROUP_COEFFS-1:0] pk_coeffs,
   input  logic                                pk_done,
   input  logic [GROUP_OUT_WIDTH-1:0]          pk_group,
   output logic                                ct_wr_en,
   output logic [GROUP_ADDR_WIDTH-1:0]         ct_wr_addr,
   output logic [GROUP_OUT_WIDTH-1:0]          ct_wr_data
);

   localparam int GW = COEFF_WIDTH * GROUP_COEFFS;
   localparam int NUM_GROUPS = KYBER_N / GROUP_COEFFS;
   localparam logic [GROUP_ADDR_WIDTH-1:0] LAST_IDX =
      GROUP_ADDR_WIDTH'(NUM_GROUPS - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      KICK,
      WAIT,
      WRITE,
      FINISH
   } state_t;

   state_t stateQ;
   state_t stateD;

   logic [GROUP_ADDR_WIDTH-1:0] idxQ;
   logic [GW-1:0]               pkCoeffsQ;
   logic [GROUP_OUT_WIDTH-1:0]  ctWrDataQ;
   logic                        wdogTrip;

`ifdef PACK_SEQ_WDOG_EN
   localparam int WDOG_W =
      ($clog2(WDOG_LIMIT + 1) > 8) ? $clog2(WDOG_LIMIT + 1) : 8;

   logic [WDOG_W-1:0] wdogCntQ;
   logic              errorQ;

   // Trip only when the limit is reached without a done in the same cycle.
   assign wdogTrip = (stateQ == WAIT) && !pk_done &&
                     (wdogCntQ == WDOG_W'(WDOG_LIMIT));

   always_ff @(posedge clk) begin
      if (reset) begin
         wdogCntQ <= '0;
         errorQ   <= 1'b0;
      end else begin
         if (stateQ == KICK) begin
            wdogCntQ <= '0;
         end else if (stateQ == WAIT) begin
            wdogCntQ <= wdogCntQ + 1'b1;
         end
         if (stateQ == IDLE && start) begin
            errorQ <= 1'b0;
         end else if (wdogTrip) begin
            errorQ <= 1'b1;
         end
      end
   end

   assign error = errorQ;
`else
   wire unusedWdogLimit = (WDOG_LIMIT == 0);

   assign wdogTrip = 1'b0;
   assign error    = 1'b0;
`endif

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         IDLE:   if (start) stateD = READ;
         READ:   stateD = LOAD;
         LOAD:   stateD = KICK;
         KICK:   stateD = WAIT;
         WAIT: begin
            if (pk_done) begin
               stateD = WRITE;
            end else if (wdogTrip) begin
               stateD = FINISH;
            end
         end
         WRITE: begin
            if (idxQ == LAST_IDX) stateD = FINISH;
            else                  stateD = READ;
         end
         FINISH: stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      coef_rd_en = 1'b0;
      pk_enable  = 1'b0;
      ct_wr_en   = 1'b0;
      busy       = (stateQ != IDLE);
      done       = (stateQ == FINISH);
      coef_rd_en = (stateQ == READ);
      pk_enable  = (stateQ == KICK);
      ct_wr_en   = (stateQ == WRITE);
   end

   assign coef_rd_addr = idxQ;
   assign ct_wr_addr   = idxQ;
   assign pk_coeffs    = pkCoeffsQ;
   assign ct_wr_data   = ctWrDataQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= IDLE;
         idxQ      <= '0;
         pkCoeffsQ <= '0;
         ctWrDataQ <= '0;
      end else begin
         stateQ <= stateD;
         unique case (stateQ)
            IDLE:  if (start) idxQ <= '0;
            LOAD:  pkCoeffsQ <= coef_rd_data;
            WAIT:  if (pk_done) ctWrDataQ <= pk_group;
            WRITE: if (idxQ != LAST_IDX) idxQ <= idxQ + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pack_poly_sequencer.sv
// tb_pack_poly_sequencer: directed bench with a stub packer, a RAM model
// and a write scoreboard for pack_poly_sequencer.
module tb_pack_poly_sequencer;

   localparam int GW = 96;
   localparam int WDOG = 255;
   localparam int PERIOD = 25;
   localparam int FULL_CYC = 32 * PERIOD + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          error;
   logic          coef_rd_en;
   logic [4:0]    coef_rd_addr;
   logic [GW-1:0] coef_rd_data = '0;
   logic          pk_enable;
   logic [GW-1:0] pk_coeffs;
   logic          pk_done = 1'b0;
   logic [23:0]   pk_group = '0;
   logic          ct_wr_en;
   logic [4:0]    ct_wr_addr;
   logic [23:0]   ct_wr_data;

   typedef struct packed {
      logic [4:0]  addr;
      logic [23:0] data;
   } wr_t;

   wr_t sb[$];
   int  nCompared = 0;
   int  nMismatched = 0;
   int  kickCount = 0;
   int  writeCount = 0;
   int  doneCount = 0;
   int  hangGroup = -1;
   bit  prevEn = 1'b0;

   logic       armed = 1'b0;
   int         dly = 0;
   logic [4:0] grp = '0;

   pack_poly_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .coef_rd_en   (coef_rd_en),
      .coef_rd_addr (coef_rd_addr),
      .coef_rd_data (coef_rd_data),
      .pk_enable    (pk_enable),
      .pk_coeffs    (pk_coeffs),
      .pk_done      (pk_done),
      .pk_group     (pk_group),
      .ct_wr_en     (ct_wr_en),
      .ct_wr_addr   (ct_wr_addr),
      .ct_wr_data   (ct_wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [GW-1:0] obs,
                        input logic [GW-1:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM: group g holds eight copies of g, one cycle read latency.
   always @(posedge clk) begin
      if (coef_rd_en) coef_rd_data <= {8{12'(coef_rd_addr)}};
   end

   // Stub packer: launch cycle, 20 silent cycles, then a done pulse.
   always @(posedge clk) begin
      if (reset) begin
         armed   <= 1'b0;
         dly     <= 0;
         pk_done <= 1'b0;
      end else begin
         pk_done <= 1'b0;
         if (pk_enable) begin
            armed <= (int'(pk_coeffs[11:0]) != hangGroup);
            dly   <= 1;
            grp   <= pk_coeffs[4:0];
         end else if (armed) begin
            if (dly == 20) begin
               pk_done  <= 1'b1;
               pk_group <= 24'hA50000 | 24'(grp);
               armed    <= 1'b0;
            end else begin
               dly <= dly + 1;
            end
         end
      end
   end

   // Monitor and scoreboard.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         prevEn = 1'b0;
      end else begin
         if (pk_enable) begin
            check("pkEnWidth", GW'(prevEn), GW'(0));
            check("pkCoeffs", pk_coeffs, {8{12'(kickCount)}});
            sb.push_back({5'(kickCount), 24'hA50000 | 24'(kickCount)});
            kickCount++;
         end
         if (ct_wr_en) begin
            if (sb.size() == 0) begin
               check("wrUnexpected", GW'(1), GW'(0));
            end else begin
               wr_t e;
               e = sb.pop_front();
               check("wrAddr", GW'(ct_wr_addr), GW'(e.addr));
               check("wrData", GW'(ct_wr_data), GW'(e.data));
            end
            writeCount++;
         end
         if (done) doneCount++;
         prevEn = pk_enable;
      end
   end

   task automatic runPoly(input string tag, input bit holdStart,
                          input int expCyc, input int expWr,
                          input int expLeft, input logic expErr);
      int cyc;
      bit busyLow;
      cyc = 0;
      busyLow = 1'b0;
      kickCount = 0;
      writeCount = 0;
      doneCount = 0;
      sb.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!holdStart) start = 1'b0;
      cyc = 1;
      check({tag, "_errClr"}, GW'(error), GW'(0));
      while (!done && cyc < 5000) begin
         if (!busy) busyLow = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_doneCyc"}, GW'(cyc), GW'(expCyc));
      check({tag, "_busyHeld"}, GW'(busyLow), GW'(0));
      check({tag, "_error"}, GW'(error), GW'(expErr));
      @(posedge clk);
      #1;
      check({tag, "_busyOff"}, GW'(busy), GW'(0));
      check({tag, "_doneOnce"}, GW'(doneCount), GW'(1));
      check({tag, "_writes"}, GW'(writeCount), GW'(expWr));
      check({tag, "_left"}, GW'(sb.size()), GW'(expLeft));
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_idle"}, GW'(busy), GW'(0));
      check({tag, "_kicks"}, GW'(kickCount), GW'(expWr + expLeft));
   endtask

   initial begin
      int t;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rstCtl",
            GW'({busy, done, error, coef_rd_en, pk_enable, ct_wr_en}),
            GW'(0));
      check("rstAddr", GW'({coef_rd_addr, ct_wr_addr}), GW'(0));
      check("rstData", GW'({pk_coeffs, ct_wr_data}), GW'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idleNoStart", GW'(busy), GW'(0));

      runPoly("full", 1'b0, FULL_CYC, 32, 0, 1'b0);
      runPoly("hold", 1'b1, FULL_CYC, 32, 0, 1'b0);

      // Abort in WAIT of group 10.
      kickCount = 0;
      sb.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t = 0;
      while (kickCount < 11 && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("reachG10", GW'(kickCount), GW'(11));
      repeat (4) @(posedge clk);
      #1;
      check("midBusy", GW'({busy, coef_rd_addr}), GW'({1'b1, 5'd10}));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midRstCtl",
            GW'({busy, done, error, coef_rd_en, pk_enable, ct_wr_en}),
            GW'(0));
      check("midRstAddr", GW'({coef_rd_addr, ct_wr_addr}), GW'(0));
      check("midRstData", GW'({pk_coeffs, ct_wr_data}), GW'(0));
      @(negedge clk);
      reset = 1'b0;
      runPoly("afterRst", 1'b0, FULL_CYC, 32, 0, 1'b0);

`ifdef PACK_SEQ_WDOG_EN
      hangGroup = 3;
      runPoly("wdog", 1'b0, 3 * PERIOD + 3 + WDOG + 2, 3, 1, 1'b1);
      check("wdogErrHeld", GW'(error), GW'(1));
      hangGroup = -1;
      runPoly("wdogRecover", 1'b0, FULL_CYC, 32, 0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/pack_poly_sequencer.md
# pack_poly_sequencer

Sequences one polynomial (KYBER_N coefficients) through the 8-coefficient group packer, one group at a time. It fetches each 96-bit coefficient group from the coefficient RAM, launches the packer with a single-cycle enable, waits for its done pulse, and writes the 24-bit packed group to the ciphertext buffer. It sits between the ciphertext-packing top-level FSM (start/done) and the group packer, and owns the packer exclusively.

## Interface
Parameters:
- KYBER_N, 256, coefficients per polynomial
- GROUP_COEFFS, 8, coefficients per packer group
- COEFF_WIDTH, 12, bits per input coefficient
- GROUP_OUT_WIDTH, 24, packed bits per group
- GROUP_ADDR_WIDTH, 5, log2(KYBER_N/GROUP_COEFFS)
- WDOG_LIMIT, 255, watchdog cycle limit (used only with PACK_SEQ_WDOG_EN)

Ports:
- clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch one polynomial; sampled in IDLE only
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- error  out  1  watchdog abort flag, held until next accepted start
- coef_rd_en  out  1  coefficient RAM read strobe
- coef_rd_addr  out  GROUP_ADDR_WIDTH  group index
- coef_rd_data  in  COEFF_WIDTH*GROUP_COEFFS  group data, valid 1 cycle after coef_rd_en; coefficient 0 in MSBs
- pk_enable  out  1  one-cycle packer launch pulse
- pk_coeffs  out  COEFF_WIDTH*GROUP_COEFFS  registered group to packer
- pk_done  in  1  packer completion pulse
- pk_group  in  GROUP_OUT_WIDTH  packed group, valid while pk_done high
- ct_wr_en  out  1  ciphertext buffer write strobe
- ct_wr_addr  out  GROUP_ADDR_WIDTH  group index
- ct_wr_data  out  GROUP_OUT_WIDTH  packed group

## Operation
- States: IDLE, READ, LOAD, KICK, WAIT, WRITE, FINISH.
- IDLE: start=1 -> READ, idx<=0, error<=0. Otherwise stay.
- READ: coef_rd_en=1, coef_rd_addr=idx -> LOAD.
- LOAD: pk_coeffs<=coef_rd_data -> KICK.
- KICK: pk_enable=1 for exactly this cycle -> WAIT.
- WAIT: pk_done=1 -> capture pk_group into ct_wr_data register -> WRITE. pk_done is ignored in every other state.
- WRITE: ct_wr_en=1, ct_wr_addr=idx. If idx==KYBER_N/GROUP_COEFFS-1 -> FINISH, else idx<=idx+1 -> READ.
- FINISH: done=1 for one cycle, busy=0 next cycle -> IDLE.
- pk_coeffs is held constant from LOAD until the next LOAD, which covers the packer's serial input capture.
- idx is GROUP_ADDR_WIDTH bits. Terminal compare at 31 for defaults, with no wrap to 0 inside a polynomial.
- start while busy: ignored, no queueing.
- start in the same cycle as FINISH: ignored. It must be re-asserted in IDLE.

## Timing
- Reset values: busy=0, done=0, error=0, coef_rd_en=0, pk_enable=0, ct_wr_en=0, all address and data outputs 0, state=IDLE, idx=0.
- Reset mid-operation: return to IDLE next cycle and deassert all strobes. Partially written buffer contents are not cleaned up. The packer must be reset by the same reset.
- Per group: 5 cycles + packer latency P, where P = cycles from pk_enable to pk_done.
- Polynomial latency from start to done: 32*(5+P)+1 cycles (defaults).
- RAM read latency is fixed at 1 cycle. There is no backpressure on the ciphertext buffer write.
- There are at least 3 cycles between a pk_done and the next pk_enable, so stale done pulses cannot be captured.

## Configuration
- PACK_SEQ_WDOG_EN defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDOG_LIMIT with no pk_done: error<=1, no write for that group, go to FINISH. done still pulses.
- PACK_SEQ_WDOG_EN undefined:
  - No counter is built; WAIT blocks indefinitely.
  - error is tied to 0.

## Test plan
- Full polynomial, stub packer with P=20 returning pk_group=24'hA50000|idx:
  - 32 writes, addresses 0..31, data 24'hA50000..24'hA5001F.
  - done pulses once at cycle 32*25+1 after start; busy=0 afterward.
- RAM loaded with group g = {8{12'(g)}}: pk_coeffs equals 96'h{8{12'(g)}} at each pk_enable, and pk_enable is exactly 1 cycle wide, 32 total.
- start held high for the whole run: exactly one polynomial is processed. A second run starts only after start is seen again in IDLE.
- reset asserted in WAIT of group 10: all outputs are at reset values the next cycle. A fresh start then writes groups 0..31 correctly.
- With PACK_SEQ_WDOG_EN and a stub that never returns pk_done for group 3:
  - Writes occur for groups 0..2 only.
  - error=1 and done pulses WDOG_LIMIT+few cycles after the group-3 kick.
  - error clears on the next start.
- Real packer, all coefficients 0: all 32 writes are 24'h000000. done pulses once.
